vip_stream_gen: RTL and testbench

- Video stream transmitter. Produces the raster stream (vsync/href/hsync + 8-bit Y) that the 3x3 matrix generators and other ISP stages consume.
- Pulls pixels from an upstream valid/ready source, typically a framebuffer-reader FIFO, and emits them on a fixed, parameterised raster timing.
- Pixels are inserted only during the active window; upstream underflow is flagged and counted.

---
 rtl/vip_stream_gen.sv | 136 +++++++++++++
 tb/tb_vip_stream_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vip_stream_gen.sv
// rtl/vip_stream_gen.sv - raster stream transmitter pulling pixels from a valid/ready source
// Optional test-pattern generator enabled by defining VIP_TPG_EN.
module vip_stream_gen #(
    parameter int          H_ACTIVE      = 640,
    parameter int          H_FP          = 16,
    parameter int          H_SYNC        = 96,
    parameter int          H_BP          = 48,
    parameter int          V_ACTIVE      = 480,
    parameter int          V_FP          = 10,
    parameter int          V_SYNC        = 2,
    parameter int          V_BP          = 33,
    parameter logic [7:0]  UNDERFLOW_VAL = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr_err,
    input  logic        tpg_sel,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic        per_frame_vsync,
    output logic        per_frame_href,
    output logic        per_frame_hsync,
    output logic [7:0]  per_img_Y,
    output logic        frame_start,
    output logic        underflow,
    output logic [15:0] underflow_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  state;
    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        run;
    logic        act;
    logic        tpg_on;
    logic        uf_evt;
    logic [7:0]  y_next;

`ifdef VIP_TPG_EN
    assign tpg_on = tpg_sel;
`else
    logic unused_tpg_sel;
    assign unused_tpg_sel = tpg_sel;
    assign tpg_on         = 1'b0;
`endif

    assign run       = (state == ST_RUN);
    assign act       = run && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign pix_ready = act && !tpg_on;
    assign uf_evt    = pix_ready && !pix_valid;

    always_comb begin
        y_next = 8'h00;
        if (act) begin
            if (tpg_on)
                y_next = h_cnt[7:0] ^ v_cnt[7:0];
            else if (pix_valid)
                y_next = pix_data;
            else
                y_next = UNDERFLOW_VAL;
        end
    end

    // Raster counters; leaving RUN is only allowed on the last clock of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state == ST_IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
            if (en)
                state <= ST_RUN;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
                if (!en)
                    state <= ST_IDLE;
            end else begin
                v_cnt <= v_cnt + 12'd1;
            end
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_frame_href  <= 1'b0;
            per_frame_hsync <= 1'b0;
            per_frame_vsync <= 1'b0;
            per_img_Y       <= 8'h00;
            frame_start     <= 1'b0;
        end else begin
            per_frame_href  <= act;
            per_frame_hsync <= run && (h_cnt >= HS_START) && (h_cnt < HS_END);
            per_frame_vsync <= run && (v_cnt >= VS_START) && (v_cnt < VS_END);
            per_img_Y       <= y_next;
            frame_start     <= act && (h_cnt == 12'd0) && (v_cnt == 12'd0);
        end
    end

    // A clear coinciding with an underflow leaves that one event recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow     <= 1'b0;
            underflow_cnt <= 16'h0000;
        end else if (clr_err) begin
            underflow     <= uf_evt;
            underflow_cnt <= uf_evt ? 16'h0001 : 16'h0000;
        end else if (uf_evt) begin
            underflow <= 1'b1;
            if (underflow_cnt != 16'hFFFF)
                underflow_cnt <= underflow_cnt + 16'h0001;
        end
    end

endmodule

// File: tb/tb_vip_stream_gen.sv
// tb/tb_vip_stream_gen.sv - directed self-checking bench for vip_stream_gen
module tb_vip_stream_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr_err;
    logic        tpg_sel;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_hsync;
    logic [7:0]  per_img_Y;
    logic        frame_start;
    logic        underflow;
    logic [15:0] underflow_cnt;

    int          checks = 0;
    int          errors = 0;
    int          uf_lo = -1;
    int          uf_hi = -1;
    int          href_cnt = 0;
    logic [7:0]  exp_word = 8'h10;
    logic        tpg = 1'b0;

    vip_stream_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .UNDERFLOW_VAL(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr_err(clr_err), .tpg_sel(tpg_sel),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
        .per_frame_hsync(per_frame_hsync), .per_img_Y(per_img_Y),
        .frame_start(frame_start), .underflow(underflow), .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: upstream source advances its word only on an actual transfer.
    task automatic cyc();
        logic xfer;
        xfer = pix_ready && pix_valid;
        @(negedge clk);
        if (xfer)
            pix_data = pix_data + 8'd1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 16'(pix_ready), 16'h0);
        chk({tag, "_href"},  16'(per_frame_href), 16'h0);
        chk({tag, "_hsync"}, 16'(per_frame_hsync), 16'h0);
        chk({tag, "_vsync"}, 16'(per_frame_vsync), 16'h0);
        chk({tag, "_y"},     16'(per_img_Y), 16'h0);
        chk({tag, "_fs"},    16'(frame_start), 16'h0);
    endtask

    // pos is the counter position (0..47) at the edge being stepped over.
    task automatic run_cycles(input int start, input int n);
        int         pos;
        int         h;
        int         v;
        logic       act;
        logic [7:0] ey;
        for (int i = 0; i < n; i++) begin
            pos = (start + i) % 48;
            h = pos % 8;
            v = pos / 8;
            act = (h < 4) && (v < 3);
            pix_valid = !(pos >= uf_lo && pos <= uf_hi);
            chk("pix_ready", 16'(pix_ready), 16'(act && !tpg));
            if (act && tpg)
                ey = 8'(h ^ v);
            else if (act && pix_valid)
                ey = exp_word;
            else
                ey = 8'h00;
            if (act && pix_valid && !tpg)
                exp_word = exp_word + 8'd1;
            cyc();
            chk("href",  16'(per_frame_href),  16'(act));
            chk("hsync", 16'(per_frame_hsync), 16'(h == 5 || h == 6));
            chk("vsync", 16'(per_frame_vsync), 16'(v == 4));
            chk("fs",    16'(frame_start),     16'(pos == 0));
            chk("y",     16'(per_img_Y),       16'(ey));
            if (per_frame_href)
                href_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr_err = 1'b0; tpg_sel = 1'b0;
        pix_valid = 1'b1; pix_data = 8'h10;
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        chk("rst_uf", 16'(underflow), 16'h0);
        chk("rst_cnt", underflow_cnt, 16'h0);

        rst_n = 1'b1;
        cyc();
        chk_all_zero("idle");
        en = 1'b1;
        cyc();
        chk("start_fs", 16'(frame_start), 16'h0);

        // Frame 1: source always valid, pixels 0x10..0x1B
        run_cycles(0, 48);
        chk("f1_href_cnt", 16'(href_cnt), 16'd12);
        chk("f1_last_word", 16'(exp_word), 16'h1C);
        chk("f1_uf", 16'(underflow), 16'h0);

        // Frame 2: underflow on the 2nd pixel of line 0
        uf_lo = 1; uf_hi = 1;
        run_cycles(0, 2);
        chk("uf_flag", 16'(underflow), 16'h1);
        chk("uf_cnt", underflow_cnt, 16'h1);
        uf_lo = -1; uf_hi = -1;
        run_cycles(2, 1);
        clr_err = 1'b1;
        run_cycles(3, 1);
        clr_err = 1'b0;
        chk("clr_flag", 16'(underflow), 16'h0);
        chk("clr_cnt", underflow_cnt, 16'h0);
        uf_lo = 8; uf_hi = 9;
        run_cycles(4, 5);
        chk("uf2_cnt", underflow_cnt, 16'h1);
        clr_err = 1'b1;
        run_cycles(9, 1);
        clr_err = 1'b0;
        chk("clr_coinc_flag", 16'(underflow), 16'h1);
        chk("clr_coinc_cnt", underflow_cnt, 16'h1);
        uf_lo = -1; uf_hi = -1;
        run_cycles(10, 38);

        // Frame 3: drop en at h=2, v=1; frame must still complete
        href_cnt = 0;
        run_cycles(0, 10);
        en = 1'b0;
        run_cycles(10, 38);
        chk("en_off_pixels", 16'(href_cnt), 16'd12);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_all_zero("idle_off");
        end
        en = 1'b1;
        cyc();
        chk("reen_fs0", 16'(frame_start), 16'h0);
        run_cycles(0, 2);

        // Asynchronous reset with counters at h=2
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("rst_restart_fs0", 16'(frame_start), 16'h0);
        run_cycles(0, 48);
        chk("rst_cnt_after", underflow_cnt, 16'h0);

`ifdef VIP_TPG_EN
        tpg_sel = 1'b1;
        tpg = 1'b1;
        pix_valid = 1'b0;
        run_cycles(0, 48);
        chk("tpg_cnt", underflow_cnt, 16'h0);
        chk("tpg_flag", 16'(underflow), 16'h0);
        tpg_sel = 1'b0;
        tpg = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
